// File: rtl/dcache_mem_responder_pkg.sv
// dcache_mem_responder_pkg: shared types and constants for the dcache
// responder model (FSM state encoding, data/mask widths, stall counter type).
package dcache_mem_responder_pkg;

  localparam int XLEN       = 32;
  localparam int MASK_W     = XLEN / 8;
  localparam int REQ_ADDR_W = 32;
  localparam int CNT_W      = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ABORT_WIN = 2'd1,
    WAIT      = 2'd2
  } state_t;

  // A request with no byte enables set is a read.
  function automatic logic is_read(input logic [MASK_W-1:0] mask);
    return (mask == {MASK_W{1'b0}});
  endfunction

endpackage

// File: rtl/dcache_mem_responder_if.sv
// dcache_mem_responder_if: request/response bundle between the core (master)
// and the dcache responder (slave). The statistics outputs exist only when
// DCACHE_MEM_RESPONDER_STATS_EN is defined.
interface dcache_mem_responder_if;
  import dcache_mem_responder_pkg::*;

  logic                  io_req_valid;
  logic [REQ_ADDR_W-1:0] io_req_bits_addr;
  logic [XLEN-1:0]       io_req_bits_data;
  logic [MASK_W-1:0]     io_req_bits_mask;
  logic                  io_abort;
  logic                  io_resp_valid;
  logic [XLEN-1:0]       io_resp_bits_data;
`ifdef DCACHE_MEM_RESPONDER_STATS_EN
  logic [31:0]           io_stat_reads;
  logic [31:0]           io_stat_writes;
  logic [31:0]           io_stat_aborts;

  modport slave (
    input  io_req_valid, io_req_bits_addr, io_req_bits_data, io_req_bits_mask, io_abort,
    output io_resp_valid, io_resp_bits_data,
    output io_stat_reads, io_stat_writes, io_stat_aborts
  );

  modport master (
    output io_req_valid, io_req_bits_addr, io_req_bits_data, io_req_bits_mask, io_abort,
    input  io_resp_valid, io_resp_bits_data,
    input  io_stat_reads, io_stat_writes, io_stat_aborts
  );
`else
  modport slave (
    input  io_req_valid, io_req_bits_addr, io_req_bits_data, io_req_bits_mask, io_abort,
    output io_resp_valid, io_resp_bits_data
  );

  modport master (
    output io_req_valid, io_req_bits_addr, io_req_bits_data, io_req_bits_mask, io_abort,
    input  io_resp_valid, io_resp_bits_data
  );
`endif

endinterface

// File: rtl/dcache_mem_responder_masked_sram.sv
// masked_sram: word-addressed scratchpad with one synchronous read port and
// one synchronous byte-masked write port. The read data register doubles as
// the response data: it only changes on a read and clears on reset.
// Array contents are never reset.
module masked_sram
  import dcache_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [XLEN-1:0]   wr_data,
  output logic [XLEN-1:0]   rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_data_r;

  // Byte-lane writes: only lanes with their enable set are updated.
  always_ff @(posedge clock) begin
    for (int b = 0; b < MASK_W; b++) begin
      if (wr_mask[b]) begin
        mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read register: loads on a read, otherwise holds the last read word.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_r <= {XLEN{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem[rd_idx];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: stands in for the dcache. Accepts one request at a
// time, stalls the core for LATENCY cycles, honours an abort in the cycle
// right after acceptance, then performs the read or byte-masked write on
// an internal scratchpad.
// Optional build macro: DCACHE_MEM_RESPONDER_STATS_EN adds 32-bit counters
// of completed reads, completed writes and aborted requests.
module dcache_mem_responder
  import dcache_mem_responder_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  dcache_mem_responder_if.slave  bus
);

  localparam cnt_t CNT_INIT = cnt_t'(LATENCY - 1);

  state_t            state_r;
  state_t            state_next_s;
  cnt_t              cnt_r;
  cnt_t              cnt_next_s;
  logic              resp_valid_r;

  logic [ADDR_W-1:0] idx_r;
  logic [XLEN-1:0]   data_r;
  logic [MASK_W-1:0] mask_r;

  logic              latch_s;
  logic              access_s;
  logic              abort_s;
  logic              rd_en_s;
  logic [MASK_W-1:0] wr_mask_s;
  logic [XLEN-1:0]   rd_data_s;

  // Address bits outside the word index are deliberately ignored.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{bus.io_req_bits_addr[REQ_ADDR_W-1:ADDR_W+2],
                              bus.io_req_bits_addr[1:0]};

  // State, stall counter and the registered ready/valid flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      resp_valid_r <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      resp_valid_r <= (state_next_s == IDLE);
    end
  end

  // Next-state, counter and access strobes for the stall sequencer.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    latch_s      = 1'b0;
    access_s     = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.io_req_valid) begin
          latch_s      = 1'b1;
          cnt_next_s   = CNT_INIT;
          state_next_s = ABORT_WIN;
        end else begin
          state_next_s = IDLE;
        end
      end
      ABORT_WIN: begin
        if (bus.io_abort) begin
          abort_s      = 1'b1;
          state_next_s = IDLE;
        end else if (cnt_r == 8'd0) begin
          access_s     = 1'b1;
          state_next_s = IDLE;
        end else begin
          cnt_next_s   = cnt_r - 8'd1;
          state_next_s = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r == 8'd0) begin
          access_s     = 1'b1;
          state_next_s = IDLE;
        end else begin
          cnt_next_s   = cnt_r - 8'd1;
          state_next_s = WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 8'd0;
      end
    endcase
  end

  // Captured request; later req fields are ignored until the next acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_r  <= {ADDR_W{1'b0}};
      data_r <= {XLEN{1'b0}};
      mask_r <= {MASK_W{1'b0}};
    end else if (latch_s) begin
      idx_r  <= bus.io_req_bits_addr[ADDR_W+1:2];
      data_r <= bus.io_req_bits_data;
      mask_r <= bus.io_req_bits_mask;
    end else begin
      idx_r  <= idx_r;
      data_r <= data_r;
      mask_r <= mask_r;
    end
  end

  // Steer the completing access to the read or write port; reset suppresses it.
  always_comb begin
    rd_en_s   = 1'b0;
    wr_mask_s = {MASK_W{1'b0}};
    if (access_s && !reset) begin
      if (is_read(mask_r)) begin
        rd_en_s = 1'b1;
      end else begin
        wr_mask_s = mask_r;
      end
    end else begin
      rd_en_s   = 1'b0;
      wr_mask_s = {MASK_W{1'b0}};
    end
  end

  masked_sram #(
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clock   (clock),
    .reset   (reset),
    .rd_en   (rd_en_s),
    .rd_idx  (idx_r),
    .wr_mask (wr_mask_s),
    .wr_idx  (idx_r),
    .wr_data (data_r),
    .rd_data (rd_data_s)
  );

  assign bus.io_resp_valid     = resp_valid_r;
  assign bus.io_resp_bits_data = rd_data_s;

`ifdef DCACHE_MEM_RESPONDER_STATS_EN
  logic [31:0] stat_reads_r;
  logic [31:0] stat_writes_r;
  logic [31:0] stat_aborts_r;

  // Event counters, bumped on the edge where the access or abort takes effect.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads_r  <= 32'd0;
      stat_writes_r <= 32'd0;
      stat_aborts_r <= 32'd0;
    end else begin
      stat_reads_r  <= stat_reads_r  + (rd_en_s ? 32'd1 : 32'd0);
      stat_writes_r <= stat_writes_r + ((wr_mask_s != {MASK_W{1'b0}}) ? 32'd1 : 32'd0);
      stat_aborts_r <= stat_aborts_r + (abort_s ? 32'd1 : 32'd0);
    end
  end

  assign bus.io_stat_reads  = stat_reads_r;
  assign bus.io_stat_writes = stat_writes_r;
  assign bus.io_stat_aborts = stat_aborts_r;
`endif

endmodule
